fxp_mul_add_unit: RTL and testbench

//  Registered signed fixed-point multiply-add datapath: MUL_OUT = A*B, SUM_OUT = A*B + C.

---
 rtl/fxp_pkg.sv | 27 ++
 rtl/fxp_mul_add_unit_if.sv | 39 +++
 rtl/fxp_resize.sv | 64 ++++++
 rtl/fxp_mul_add_unit.sv | 112 +++++++++++
 tb/tb_fxp_mul_add_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared helpers for the fixed-point multiply-add slice:
//                max() and the aligned integer/fraction widths used when the
//                full-precision product and the addend are summed.
//  Revision    : 1.0  initial release
// ============================================================================
package fxp_pkg;

    // Larger of two widths
    function automatic int fxp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Integer bits of the aligned sum: widest operand plus one carry bit
    function automatic int fxp_sum_int_bits(input int wia, input int wib, input int wic);
        return fxp_max(wia + wib, wic) + 1;
    endfunction

    // Fraction bits of the aligned sum: finest operand resolution
    function automatic int fxp_sum_frac_bits(input int wfa, input int wfb, input int wfc);
        return fxp_max(wfa + wfb, wfc);
    endfunction

endpackage : fxp_pkg
`default_nettype wire

// File: rtl/fxp_mul_add_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mul_add_unit_if
//  Description : Operand / result bundle of the fixed-point multiply-add unit.
//                master drives operands, slave (the datapath) returns results.
//  Revision    : 1.0  initial release
// ============================================================================
interface fxp_mul_add_unit_if #(
    parameter int WIA = 4,
    parameter int WFA = 5,
    parameter int WIB = 4,
    parameter int WFB = 5,
    parameter int WIC = 8,
    parameter int WFC = 10,
    parameter int WIO = 8,
    parameter int WFO = 10
);
    logic                          IN_VALID;
    logic signed [WIA+WFA-1:0]     A;
    logic signed [WIB+WFB-1:0]     B;
    logic signed [WIC+WFC-1:0]     C;
    logic                          OUT_VALID;
    logic signed [WIO+WFO-1:0]     MUL_OUT;
    logic signed [WIO+WFO-1:0]     SUM_OUT;
    logic                          OVF_MUL;
    logic                          OVF_ADD;
    logic                          OVERFLOW;

    modport master (
        output IN_VALID, A, B, C,
        input  OUT_VALID, MUL_OUT, SUM_OUT, OVF_MUL, OVF_ADD, OVERFLOW
    );

    modport slave (
        input  IN_VALID, A, B, C,
        output OUT_VALID, MUL_OUT, SUM_OUT, OVF_MUL, OVF_ADD, OVERFLOW
    );
endinterface : fxp_mul_add_unit_if
`default_nettype wire

// File: rtl/fxp_resize.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_resize
//  Description : Combinational signed fixed-point resize WII.WFI -> WIO.WFO.
//                Fraction reduction floors, fraction extension zero-pads,
//                integer reduction keeps the low bits and flags overflow when
//                the dropped MSBs differ from the kept sign bit.
//                Build option FXP_SATURATE_EN: clamp overflowing results to
//                the max/min code by the sign of the input (flag unchanged);
//                otherwise the wrapped low bits are passed through.
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_resize #(
    parameter int WII = 8,
    parameter int WFI = 10,
    parameter int WIO = 8,
    parameter int WFO = 10
) (
    input  logic signed [WII+WFI-1:0] in_val,
    output logic signed [WIO+WFO-1:0] out_val,
    output logic                      ovf
);
    localparam int c_WI = WII + WFI;   // input width
    localparam int c_WM = WII + WFO;   // after fraction adjust
    localparam int c_WO = WIO + WFO;   // output width

    logic signed [c_WM-1:0] w_frac;
    logic signed [c_WO-1:0] w_kept;
    logic                   w_ovf;

    // Fraction adjust: arithmetic right shift floors, left shift zero-pads
    generate
        if (WFO < WFI) begin : g_frac_trunc
            assign w_frac = c_WM'(in_val >>> (WFI - WFO));
        end else begin : g_frac_pad
            assign w_frac = c_WM'(in_val) <<< (WFO - WFI);
        end
    endgenerate

    // Integer adjust: drop MSBs (detecting loss of sign) or sign-extend
    generate
        if (WIO < WII) begin : g_int_trunc
            logic [c_WM-c_WO:0] w_top;
            assign w_top  = w_frac[c_WM-1:c_WO-1];
            assign w_kept = w_frac[c_WO-1:0];
            assign w_ovf  = !((&w_top) || !(|w_top));
        end else begin : g_int_ext
            assign w_kept = c_WO'(w_frac);
            assign w_ovf  = 1'b0;
        end
    endgenerate

`ifdef FXP_SATURATE_EN
    // Clamp toward the sign of the exact value on overflow
    assign out_val = !w_ovf               ? w_kept :
                     in_val[c_WI-1]       ? {1'b1, {(c_WO-1){1'b0}}} :
                                            {1'b0, {(c_WO-1){1'b1}}};
`else
    assign out_val = w_kept;
`endif
    assign ovf = w_ovf;

endmodule : fxp_resize
`default_nettype wire

// File: rtl/fxp_mul_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mul_add_unit
//  Description : Registered signed fixed-point multiply-add (MAC element).
//                MUL_OUT = A*B, SUM_OUT = A*B + C, both resized to WIO.WFO
//                with per-sample overflow flags; one-cycle latency.
//                Build option FXP_SATURATE_EN selects saturation instead of
//                wrap in the two fxp_resize instances.
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_mul_add_unit
    import fxp_pkg::*;
#(
    parameter int WIA = 4,
    parameter int WFA = 5,
    parameter int WIB = 4,
    parameter int WFB = 5,
    parameter int WIC = 8,
    parameter int WFC = 10,
    parameter int WIO = 8,
    parameter int WFO = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    fxp_mul_add_unit_if.slave  bus
);
    // Full-precision product format
    localparam int c_WIP = WIA + WIB;
    localparam int c_WFP = WFA + WFB;
    localparam int c_WP  = c_WIP + c_WFP;
    // Aligned sum format
    localparam int c_I   = fxp_sum_int_bits(WIA, WIB, WIC);
    localparam int c_F   = fxp_sum_frac_bits(WFA, WFB, WFC);
    localparam int c_WS  = c_I + c_F;
    localparam int c_WO  = WIO + WFO;

    logic signed [c_WP-1:0] w_prod;
    logic signed [c_WS-1:0] w_prod_al;
    logic signed [c_WS-1:0] w_c_al;
    logic signed [c_WS-1:0] w_sum;
    logic signed [c_WO-1:0] w_mul_rs;
    logic signed [c_WO-1:0] w_sum_rs;
    logic                   w_ovf_mul;
    logic                   w_ovf_add;

    logic                   r_out_valid;
    logic signed [c_WO-1:0] r_mul;
    logic signed [c_WO-1:0] r_sum;
    logic                   r_ovf_mul;
    logic                   r_ovf_add;
    logic                   r_overflow;

    // Exact product: operands widen to c_WP before multiplying, so min*min fits
    assign w_prod    = c_WP'(bus.A) * c_WP'(bus.B);

    // Align both terms to c_I.c_F by sign-extension and left shift, then add
    assign w_prod_al = c_WS'(w_prod) <<< (c_F - c_WFP);
    assign w_c_al    = c_WS'(bus.C)  <<< (c_F - WFC);
    assign w_sum     = w_prod_al + w_c_al;

    fxp_resize #(
        .WII (c_WIP),
        .WFI (c_WFP),
        .WIO (WIO),
        .WFO (WFO)
    ) u_resize_mul (
        .in_val  (w_prod),
        .out_val (w_mul_rs),
        .ovf     (w_ovf_mul)
    );

    fxp_resize #(
        .WII (c_I),
        .WFI (c_F),
        .WIO (WIO),
        .WFO (WFO)
    ) u_resize_sum (
        .in_val  (w_sum),
        .out_val (w_sum_rs),
        .ovf     (w_ovf_add)
    );

    // Output registers: capture on IN_VALID, hold otherwise; reset clears all
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_mul       <= '0;
            r_sum       <= '0;
            r_ovf_mul   <= 1'b0;
            r_ovf_add   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                r_mul      <= w_mul_rs;
                r_sum      <= w_sum_rs;
                r_ovf_mul  <= w_ovf_mul;
                r_ovf_add  <= w_ovf_add;
                r_overflow <= w_ovf_mul | w_ovf_add;
            end
        end
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.MUL_OUT   = r_mul;
    assign bus.SUM_OUT   = r_sum;
    assign bus.OVF_MUL   = r_ovf_mul;
    assign bus.OVF_ADD   = r_ovf_add;
    assign bus.OVERFLOW  = r_overflow;

endmodule : fxp_mul_add_unit
`default_nettype wire

// File: tb/tb_fxp_mul_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxp_mul_add_unit
//  Description : Scoreboard bench for fxp_mul_add_unit. Two instances: the
//                default 8.10 output format and a narrow 4.5 output format.
//                Expected results come from integer arithmetic on the real
//                values (or from fixed reference values for directed vectors).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fxp_mul_add_unit;

    localparam int WIA = 4, WFA = 5, WIB = 4, WFB = 5, WIC = 8, WFC = 10;
    localparam int WIO0 = 8, WFO0 = 10;
    localparam int WIO1 = 4, WFO1 = 5;

    typedef struct packed {
        longint mul;
        longint sum;
        logic   om;
        logic   oa;
    } exp_t;

`ifdef FXP_SATURATE_EN
    localparam longint V4_SUM0  = 131071;
    localparam longint V5_MUL1  = 255;
`else
    localparam longint V4_SUM0  = -129024;
    localparam longint V5_MUL1  = 0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    fxp_mul_add_unit_if #(.WIO(WIO0), .WFO(WFO0)) bus0 ();
    fxp_mul_add_unit_if #(.WIO(WIO1), .WFO(WFO1)) bus1 ();

    fxp_mul_add_unit #(.WIO(WIO0), .WFO(WFO0)) u_dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus0.slave)
    );

    fxp_mul_add_unit #(.WIO(WIO1), .WFO(WFO1)) u_dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1.slave)
    );

    initial forever #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q [2][$];
    exp_t last_e [2];
    logic rst_at_edge = 1'b0;

    always @(posedge CLK) rst_at_edge <= RESET;

    // ---------------- reference model ----------------
    // Rescale an integer with from_f fraction bits to to_f bits, flooring
    function automatic longint rescale(input longint v, input int from_f, input int to_f);
        if (to_f >= from_f) return v * (longint'(1) <<< (to_f - from_f));
        return v >>> (from_f - to_f);
    endfunction

    // Fit an exact value into a wo-bit two's complement code
    function automatic void fit(input longint v, input int wo, output longint r, output logic ovf);
        longint lim, span;
        lim  = longint'(1) <<< (wo - 1);
        span = longint'(1) <<< wo;
        ovf  = (v < -lim) || (v > lim - 1);
`ifdef FXP_SATURATE_EN
        if (!ovf)        r = v;
        else if (v < 0)  r = -lim;
        else             r = lim - 1;
`else
        r = ((v % span) + span) % span;
        if (r >= lim) r = r - span;
`endif
    endfunction

    function automatic exp_t model(input longint a, input longint b, input longint c,
                                   input int wio, input int wfo);
        exp_t   e;
        longint p, s, r;
        logic   o;
        int     fp, f;
        fp = WFA + WFB;
        f  = (fp > WFC) ? fp : WFC;
        p  = a * b;                                   // exact, fp fraction bits
        s  = rescale(p, fp, f) + rescale(c, WFC, f);  // exact, f fraction bits
        fit(rescale(p, fp, wfo), wio + wfo, r, o);
        e.mul = r; e.om = o;
        fit(rescale(s, f, wfo), wio + wfo, r, o);
        e.sum = r; e.oa = o;
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic rst_e, input logic ov,
                       input longint mul, input longint sum,
                       input logic om, input logic oa, input logic ovf);
        exp_t e;
        string t;
        t = $sformatf("d%0d", d);
        if (rst_e) begin
            last_e[d] = '0;
            chk({t, " reset valid"}, longint'(ov), 0);
        end else if (ov) begin
            if (q[d].size() == 0) begin
                chk({t, " unexpected valid"}, 1, 0);
                return;
            end
            e = q[d].pop_front();
            last_e[d] = e;
        end else begin
            chk({t, " idle valid"}, longint'(ov), 0);
        end
        // results are either fresh, held, or zeroed by reset
        chk({t, " mul"},      mul, last_e[d].mul);
        chk({t, " sum"},      sum, last_e[d].sum);
        chk({t, " ovf_mul"},  longint'(om),  longint'(last_e[d].om));
        chk({t, " ovf_add"},  longint'(oa),  longint'(last_e[d].oa));
        chk({t, " overflow"}, longint'(ovf), longint'(last_e[d].om | last_e[d].oa));
    endtask

    always @(negedge CLK)
        mon(0, rst_at_edge, bus0.OUT_VALID, longint'(bus0.MUL_OUT), longint'(bus0.SUM_OUT),
            bus0.OVF_MUL, bus0.OVF_ADD, bus0.OVERFLOW);

    always @(negedge CLK)
        mon(1, rst_at_edge, bus1.OUT_VALID, longint'(bus1.MUL_OUT), longint'(bus1.SUM_OUT),
            bus1.OVF_MUL, bus1.OVF_ADD, bus1.OVERFLOW);

    // ---------------- stimulus ----------------
    task automatic issue(input logic rst, input logic v,
                         input longint a, input longint b, input longint c,
                         input logic t0, input exp_t e0, input logic t1, input exp_t e1);
        RESET         = rst;
        bus0.IN_VALID = v;  bus1.IN_VALID = v;
        bus0.A = 9'(a);     bus1.A = 9'(a);
        bus0.B = 9'(b);     bus1.B = 9'(b);
        bus0.C = 18'(c);    bus1.C = 18'(c);
        if (v && !rst) begin
            q[0].push_back(t0 ? e0 : model(a, b, c, WIO0, WFO0));
            q[1].push_back(t1 ? e1 : model(a, b, c, WIO1, WFO1));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input longint a, input longint b, input longint c);
        issue(1'b0, 1'b1, a, b, c, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic longint rnd(input int w);
        longint v;
        v = longint'($urandom_range(0, (1 << w) - 1));
        if (v >= (longint'(1) <<< (w - 1))) v = v - (longint'(1) <<< w);
        return v;
    endfunction

    initial begin
        longint a, b, c;
        int     wait_cyc;
        last_e[0] = '0;
        last_e[1] = '0;
        bus0.IN_VALID = 1'b0; bus1.IN_VALID = 1'b0;
        bus0.A = '0; bus0.B = '0; bus0.C = '0;
        bus1.A = '0; bus1.B = '0; bus1.C = '0;
        repeat (2) issue(1'b1, 1'b0, 0, 0, 0, 1'b0, '0, 1'b0, '0);

        // directed vectors with reference values
        issue(1'b0, 1'b1, 48, 64, 0,         1'b1, '{3072, 3072, 1'b0, 1'b0},     1'b0, '0);
        issue(1'b0, 1'b1, -32, 16, 1024,     1'b1, '{-512, 512, 1'b0, 1'b0},      1'b0, '0);
        issue(1'b0, 1'b1, -256, -256, 0,     1'b1, '{65536, 65536, 1'b0, 1'b0},   1'b0, '0);
        issue(1'b0, 1'b1, 48, 64, 130048,    1'b1, '{3072, V4_SUM0, 1'b0, 1'b1},  1'b0, '0);
        issue(1'b0, 1'b0, 0, 0, 0,           1'b0, '0, 1'b0, '0);   // hold check
        issue(1'b0, 1'b1, 128, 128, 0,       1'b0, '0, 1'b1, '{V5_MUL1, V5_MUL1, 1'b1, 1'b1});
        issue(1'b0, 1'b1, 1, 1, 0,           1'b0, '0, 1'b1, '{0, 0, 1'b0, 1'b0});
        issue(1'b0, 1'b1, -1, 1, 0,          1'b0, '0, 1'b1, '{-1, -1, 1'b0, 1'b0});
        issue(1'b0, 1'b0, 0, 0, 0,           1'b0, '0, 1'b0, '0);
        // reset beats a simultaneous IN_VALID
        issue(1'b1, 1'b1, 48, 64, 0,         1'b0, '0, 1'b0, '0);
        go(-256, 255, 131071);
        go(-256, -256, -131072);

        // randomized traffic with idle gaps and occasional resets
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? -256 : 255) : rnd(9);
            b = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? -256 : 255) : rnd(9);
            c = ($urandom_range(0, 3) == 0) ? rnd(12) : rnd(18);
            issue($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, a, b, c,
                  1'b0, '0, 1'b0, '0);
        end

        repeat (2) issue(1'b0, 1'b0, 0, 0, 0, 1'b0, '0, 1'b0, '0);
        wait_cyc = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && wait_cyc < 10) begin
            @(posedge CLK);
            wait_cyc++;
        end
        n_checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d pending results, expected 0/0",
                     q[0].size(), q[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fxp_mul_add_unit
`default_nettype wire
